// File: rtl/bp_cce_deserializer.sv
// Coalesces pairs of 32-bit BedRock mem command beats into one 64-bit command and
// splits the 64-bit response back into two 32-bit beats. Optional checking: BP_CCE_DESERIALIZER_CHECK_EN.
module bp_cce_deserializer
  #(parameter int bp_params_p = 0  // 0 selects e_bp_default_cfg
  , localparam int paddr_width_p = (bp_params_p == 0) ? 40 : 56
  , localparam int lce_id_width_p = 4
  , localparam int lce_assoc_p = 8
  , localparam int dword_width_gp = 64
  , localparam int word_width_gp = 32
  , localparam int way_width_lp = $clog2(lce_assoc_p)
  , localparam int payload_width_lp = lce_id_width_p + way_width_lp
  , localparam int addr_lsb_lp = 8
  , localparam int size_lsb_lp = addr_lsb_lp + paddr_width_p
  , localparam int hdr_width_lp = size_lsb_lp + 3 + payload_width_lp
  , localparam int cce_mem_msg_width_lp = hdr_width_lp + dword_width_gp
  , localparam int split_mem_msg_width_lp = hdr_width_lp + word_width_gp
  )
  (input  logic                              clk_i
  , input  logic                              reset_ni
  , input  logic [split_mem_msg_width_lp-1:0] io_cmd_i
  , input  logic                              io_cmd_v_i
  , output logic                              io_cmd_ready_and_o
  , output logic [split_mem_msg_width_lp-1:0] io_resp_o
  , output logic                              io_resp_v_o
  , input  logic                              io_resp_ready_and_i
  , output logic [cce_mem_msg_width_lp-1:0]   io_cmd_o
  , output logic                              io_cmd_v_o
  , input  logic                              io_cmd_ready_and_i
  , input  logic [cce_mem_msg_width_lp-1:0]   io_resp_i
  , input  logic                              io_resp_v_i
  , output logic                              io_resp_ready_and_o
  , output logic                              error_o
  );

  typedef enum logic [2:0] {
    e_bedrock_msg_size_1 = 3'd0,
    e_bedrock_msg_size_2 = 3'd1,
    e_bedrock_msg_size_4 = 3'd2,
    e_bedrock_msg_size_8 = 3'd3
  } bp_bedrock_msg_size_e;

  typedef enum logic [2:0] {e_lo, e_hi, e_send, e_wait, e_resp_lo, e_resp_hi} state_e;

  state_e state, state_n;

  logic [hdr_width_lp-1:0]   cmd_hdr_r, resp_hdr_r, cmd_hdr, resp_hdr;
  logic [word_width_gp-1:0]  lo_word_r, hi_word_r;
  logic [dword_width_gp-1:0] resp_data_r;
  logic [paddr_width_p-1:0]  base_addr, hi_addr;
  logic                      cmd_hs, wide_resp_hs;
  logic                      unused_bits;

  assign cmd_hs       = io_cmd_v_i & io_cmd_ready_and_o;
  assign wide_resp_hs = io_resp_v_i & io_resp_ready_and_o;
  assign base_addr    = cmd_hdr_r[addr_lsb_lp+:paddr_width_p];
  assign hi_addr      = base_addr + paddr_width_p'(4);
  assign unused_bits  = ^{cmd_hdr_r[size_lsb_lp+:3], resp_hdr_r[size_lsb_lp+:3],
                          resp_hdr_r[addr_lsb_lp+:paddr_width_p]};

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) state <= e_lo;
    else           state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      e_lo:      if (cmd_hs) state_n = e_hi;
      e_hi:      if (cmd_hs) state_n = e_send;
      e_send:    if (io_cmd_ready_and_i) state_n = e_wait;
      e_wait:    if (wide_resp_hs) state_n = e_resp_lo;
      e_resp_lo: if (io_resp_ready_and_i) state_n = e_resp_hi;
      e_resp_hi: if (io_resp_ready_and_i) state_n = e_lo;
      default:   state_n = e_lo;
    endcase
  end

  // Command ready is gated by reset so it reads 0 while reset is held.
  always_comb begin
    io_cmd_ready_and_o  = reset_ni & ((state == e_lo) | (state == e_hi));
    io_cmd_v_o          = (state == e_send);
    io_resp_ready_and_o = (state == e_wait);
    io_resp_v_o         = (state == e_resp_lo) | (state == e_resp_hi);

    cmd_hdr = cmd_hdr_r;
    cmd_hdr[size_lsb_lp+:3] = e_bedrock_msg_size_8;
    io_cmd_o = {hi_word_r, lo_word_r, cmd_hdr};

    resp_hdr = resp_hdr_r;
    resp_hdr[size_lsb_lp+:3] = e_bedrock_msg_size_4;
    resp_hdr[addr_lsb_lp+:paddr_width_p] = (state == e_resp_hi) ? hi_addr : base_addr;
    io_resp_o = {((state == e_resp_hi) ? resp_data_r[dword_width_gp-1:word_width_gp]
                                       : resp_data_r[word_width_gp-1:0]), resp_hdr};
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      cmd_hdr_r   <= '0;
      resp_hdr_r  <= '0;
      lo_word_r   <= '0;
      hi_word_r   <= '0;
      resp_data_r <= '0;
    end else begin
      if (cmd_hs && state == e_lo) begin
        cmd_hdr_r <= io_cmd_i[hdr_width_lp-1:0];
        lo_word_r <= io_cmd_i[hdr_width_lp+:word_width_gp];
      end
      if (cmd_hs && state == e_hi)
        hi_word_r <= io_cmd_i[hdr_width_lp+:word_width_gp];
      if (wide_resp_hs) begin
        resp_hdr_r  <= io_resp_i[hdr_width_lp-1:0];
        resp_data_r <= io_resp_i[hdr_width_lp+:dword_width_gp];
      end
    end
  end

`ifdef BP_CCE_DESERIALIZER_CHECK_EN
  logic                     error_r, beat_fault;
  logic [paddr_width_p-1:0] beat_addr;

  always_comb begin
    beat_addr  = io_cmd_i[addr_lsb_lp+:paddr_width_p];
    beat_fault = 1'b0;
    if (state == e_lo)
      beat_fault = (io_cmd_i[size_lsb_lp+:3] != e_bedrock_msg_size_4) | beat_addr[2];
    else if (state == e_hi)
      beat_fault = (io_cmd_i[3:0] != cmd_hdr_r[3:0]) | (beat_addr != hi_addr);
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni)                 error_r <= 1'b0;
    else if (cmd_hs && beat_fault) error_r <= 1'b1;
  end

  assign error_o = error_r;
`else
  assign error_o = 1'b0;
`endif

endmodule

// File: tb/tb_bp_cce_deserializer.sv
// Self-checking bench for bp_cce_deserializer: directed scenarios plus randomized
// command pairs checked against a message-level model of coalescing and splitting.
module tb_bp_cce_deserializer;
  localparam int PA = 40;
  localparam int HW = 58;
  localparam int NW = HW + 32;
  localparam int WW = HW + 64;

  logic clk = 1'b0;
  logic reset_ni = 1'b0;
  logic [NW-1:0] io_cmd_i = '0;
  logic io_cmd_v_i = 1'b0;
  logic io_cmd_ready_and_o;
  logic [NW-1:0] io_resp_o;
  logic io_resp_v_o;
  logic io_resp_ready_and_i = 1'b0;
  logic [WW-1:0] io_cmd_o;
  logic io_cmd_v_o;
  logic io_cmd_ready_and_i = 1'b0;
  logic [WW-1:0] io_resp_i = '0;
  logic io_resp_v_i = 1'b0;
  logic io_resp_ready_and_o;
  logic error_o;

  int checks = 0;
  int failures = 0;
  bit exp_err;

  always #5 clk = ~clk;

  bp_cce_deserializer dut (
    .clk_i(clk), .reset_ni(reset_ni),
    .io_cmd_i(io_cmd_i), .io_cmd_v_i(io_cmd_v_i), .io_cmd_ready_and_o(io_cmd_ready_and_o),
    .io_resp_o(io_resp_o), .io_resp_v_o(io_resp_v_o), .io_resp_ready_and_i(io_resp_ready_and_i),
    .io_cmd_o(io_cmd_o), .io_cmd_v_o(io_cmd_v_o), .io_cmd_ready_and_i(io_cmd_ready_and_i),
    .io_resp_i(io_resp_i), .io_resp_v_i(io_resp_v_i), .io_resp_ready_and_o(io_resp_ready_and_o),
    .error_o(error_o));

  // Header layout: {payload[6:0], size[2:0], addr[39:0], subop[3:0], opcode[3:0]}
  function automatic logic [HW-1:0] mk_hdr(input logic [3:0] op, input logic [3:0] sub,
                                           input logic [PA-1:0] addr, input logic [2:0] sz,
                                           input logic [6:0] pl);
    return {pl, sz, addr, sub, op};
  endfunction

  function automatic bit faulty(input logic [2:0] sz1, input logic [PA-1:0] a1, input logic [3:0] op1,
                                input logic [3:0] op2, input logic [PA-1:0] a2);
    logic [PA-1:0] nxt;
    nxt = a1 + 40'd4;
`ifdef BP_CCE_DESERIALIZER_CHECK_EN
    return (sz1 != 3'd2) || a1[2] || (op1 != op2) || (a2 != nxt);
`else
    return 1'b0;
`endif
  endfunction

  task automatic put_beat(input logic [NW-1:0] m, output bit ok);
    ok = 0; io_cmd_i = m; io_cmd_v_i = 1'b1;
    for (int i = 0; i < 40 && !ok; i++) begin
      if (io_cmd_ready_and_o) ok = 1;
      @(negedge clk);
    end
    io_cmd_v_i = 1'b0;
  endtask

  task automatic get_wide(output logic [WW-1:0] m, output bit ok);
    ok = 0; m = '0; io_cmd_ready_and_i = 1'b1;
    for (int i = 0; i < 40 && !ok; i++) begin
      if (io_cmd_v_o) begin m = io_cmd_o; ok = 1; end
      @(negedge clk);
    end
    io_cmd_ready_and_i = 1'b0;
  endtask

  task automatic put_resp(input logic [WW-1:0] m, output bit ok);
    ok = 0; io_resp_i = m; io_resp_v_i = 1'b1;
    for (int i = 0; i < 40 && !ok; i++) begin
      if (io_resp_ready_and_o) ok = 1;
      @(negedge clk);
    end
    io_resp_v_i = 1'b0;
  endtask

  task automatic get_narrow(output logic [NW-1:0] m, output bit ok);
    ok = 0; m = '0; io_resp_ready_and_i = 1'b1;
    for (int i = 0; i < 40 && !ok; i++) begin
      if (io_resp_v_o) begin m = io_resp_o; ok = 1; end
      @(negedge clk);
    end
    io_resp_ready_and_i = 1'b0;
  endtask

  task automatic do_txn(input logic [NW-1:0] b1, input logic [NW-1:0] b2, input logic [WW-1:0] wr,
                        output logic [WW-1:0] w, output logic [NW-1:0] r0, output logic [NW-1:0] r1,
                        output bit ok, output bit lat_cmd, output bit lat_resp, output bit rdy_after);
    bit o1, o2, o3, o4, o5, o6;
    put_beat(b1, o1);
    put_beat(b2, o2);
    lat_cmd = io_cmd_v_o;
    get_wide(w, o3);
    put_resp(wr, o4);
    lat_resp = io_resp_v_o;
    get_narrow(r0, o5);
    get_narrow(r1, o6);
    rdy_after = io_cmd_ready_and_o;
    ok = o1 & o2 & o3 & o4 & o5 & o6;
  endtask

  task automatic test_reset;
    #12;
    checks++; if (io_cmd_v_o !== 1'b0) begin failures++; $display("FAIL rst_cmd_v got %b want 0", io_cmd_v_o); end
    checks++; if (io_resp_v_o !== 1'b0) begin failures++; $display("FAIL rst_resp_v got %b want 0", io_resp_v_o); end
    checks++; if (io_cmd_ready_and_o !== 1'b0) begin failures++; $display("FAIL rst_cmd_rdy got %b want 0", io_cmd_ready_and_o); end
    checks++; if (io_resp_ready_and_o !== 1'b0) begin failures++; $display("FAIL rst_resp_rdy got %b want 0", io_resp_ready_and_o); end
    checks++; if (error_o !== 1'b0) begin failures++; $display("FAIL rst_err got %b want 0", error_o); end
    checks++; if (io_cmd_o[WW-1:HW] !== 64'h0) begin failures++; $display("FAIL rst_cmd_data got %h want 0", io_cmd_o[WW-1:HW]); end
    checks++; if (io_resp_o[NW-1:HW] !== 32'h0) begin failures++; $display("FAIL rst_resp_data got %h want 0", io_resp_o[NW-1:HW]); end
    @(negedge clk);
    reset_ni = 1'b1;
    #1;
    checks++; if (io_cmd_ready_and_o !== 1'b1) begin failures++; $display("FAIL post_rst_rdy got %b want 1", io_cmd_ready_and_o); end
  endtask

  task automatic test_write_pair;
    logic [WW-1:0] w, wexp;
    logic [NW-1:0] r0, r1;
    bit ok, lc, lr, ra;
    wexp = {64'h3333_4444_1111_2222, mk_hdr(4'h1, 4'h0, 40'h00_8000_0000, 3'd3, 7'h15)};
    do_txn({32'h1111_2222, mk_hdr(4'h1, 4'h0, 40'h00_8000_0000, 3'd2, 7'h15)},
           {32'h3333_4444, mk_hdr(4'h1, 4'h0, 40'h00_8000_0004, 3'd2, 7'h15)},
           {64'h0, mk_hdr(4'h1, 4'h0, 40'h00_8000_0000, 3'd3, 7'h15)}, w, r0, r1, ok, lc, lr, ra);
    checks++; if (!ok) begin failures++; $display("FAIL wr_handshake got timeout want done"); end
    checks++; if (w !== wexp) begin failures++; $display("FAIL wr_wide got %h want %h", w, wexp); end
    checks++; if (!lc) begin failures++; $display("FAIL wr_cmd_latency got 0 want 1"); end
    checks++; if (!lr) begin failures++; $display("FAIL wr_resp_latency got 0 want 1"); end
    checks++; if (!ra) begin failures++; $display("FAIL wr_turnaround got 0 want 1"); end
    checks++; if (error_o !== 1'b0) begin failures++; $display("FAIL wr_err got %b want 0", error_o); end
  endtask

  task automatic test_read_pair;
    logic [WW-1:0] w, wexp;
    logic [NW-1:0] r0, r1, e0, e1;
    bit ok, lc, lr, ra;
    wexp = {64'h0, mk_hdr(4'h0, 4'h3, 40'h100, 3'd3, 7'h2a)};
    e0 = {32'hCAFE_F00D, mk_hdr(4'h0, 4'h5, 40'h100, 3'd2, 7'h2a)};
    e1 = {32'hDEAD_BEEF, mk_hdr(4'h0, 4'h5, 40'h104, 3'd2, 7'h2a)};
    do_txn({32'h0, mk_hdr(4'h0, 4'h3, 40'h100, 3'd2, 7'h2a)},
           {32'h0, mk_hdr(4'h0, 4'h3, 40'h104, 3'd2, 7'h2a)},
           {64'hDEAD_BEEF_CAFE_F00D, mk_hdr(4'h0, 4'h5, 40'h7700, 3'd3, 7'h2a)}, w, r0, r1, ok, lc, lr, ra);
    checks++; if (!ok) begin failures++; $display("FAIL rd_handshake got timeout want done"); end
    checks++; if (w !== wexp) begin failures++; $display("FAIL rd_wide got %h want %h", w, wexp); end
    checks++; if (r0 !== e0) begin failures++; $display("FAIL rd_resp_lo got %h want %h", r0, e0); end
    checks++; if (r1 !== e1) begin failures++; $display("FAIL rd_resp_hi got %h want %h", r1, e1); end
  endtask

  task automatic test_cmd_stall;
    logic [WW-1:0] m0, w, wexp;
    logic [NW-1:0] r;
    bit o1, o2, o3;
    wexp = {64'hBBBB_0002_AAAA_0001, mk_hdr(4'h1, 4'h2, 40'h40, 3'd3, 7'h01)};
    put_beat({32'hAAAA_0001, mk_hdr(4'h1, 4'h2, 40'h40, 3'd2, 7'h01)}, o1);
    put_beat({32'hBBBB_0002, mk_hdr(4'h1, 4'h2, 40'h44, 3'd2, 7'h01)}, o2);
    m0 = io_cmd_o;
    io_cmd_i = {32'hCCCC_0003, mk_hdr(4'h1, 4'h2, 40'h48, 3'd2, 7'h01)};
    io_cmd_v_i = 1'b1;
    io_resp_v_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checks++; if (io_cmd_v_o !== 1'b1) begin failures++; $display("FAIL stall_v got %b want 1", io_cmd_v_o); end
      checks++; if (io_cmd_o !== m0) begin failures++; $display("FAIL stall_cmd got %h want %h", io_cmd_o, m0); end
      checks++; if (io_cmd_ready_and_o !== 1'b0) begin failures++; $display("FAIL stall_third_beat got %b want 0", io_cmd_ready_and_o); end
      checks++; if (io_resp_ready_and_o !== 1'b0) begin failures++; $display("FAIL stall_resp_rdy got %b want 0", io_resp_ready_and_o); end
      @(negedge clk);
    end
    io_cmd_v_i = 1'b0;
    io_resp_v_i = 1'b0;
    get_wide(w, o3);
    checks++; if (!(o1 && o2 && o3)) begin failures++; $display("FAIL stall_handshake got timeout want done"); end
    checks++; if (w !== wexp) begin failures++; $display("FAIL stall_wide got %h want %h", w, wexp); end
    put_resp({64'h1, mk_hdr(4'h1, 4'h0, 40'h0, 3'd3, 7'h0)}, o1);
    get_narrow(r, o2);
    get_narrow(r, o3);
    checks++; if (!(o1 && o2 && o3 && io_cmd_ready_and_o)) begin failures++; $display("FAIL stall_finish got %b want 1", io_cmd_ready_and_o); end
  endtask

  task automatic test_resp_backpressure;
    logic [WW-1:0] w;
    logic [NW-1:0] ex [2];
    int k;
    bit o1, o2, o3, o4, o5;
    ex[0] = {32'h5555_6666, mk_hdr(4'h0, 4'h1, 40'h200, 3'd2, 7'h33)};
    ex[1] = {32'h7777_8888, mk_hdr(4'h0, 4'h1, 40'h204, 3'd2, 7'h33)};
    put_beat({32'h0, mk_hdr(4'h0, 4'h0, 40'h200, 3'd2, 7'h10)}, o1);
    put_beat({32'h0, mk_hdr(4'h0, 4'h0, 40'h204, 3'd2, 7'h10)}, o2);
    get_wide(w, o3);
    put_resp({64'h7777_8888_5555_6666, mk_hdr(4'h0, 4'h1, 40'hABC, 3'd3, 7'h33)}, o4);
    k = 0;
    for (int c = 0; c < 40 && k < 2; c++) begin
      checks++; if (io_resp_v_o !== 1'b1) begin failures++; $display("FAIL bp_v beat %0d got %b want 1", k, io_resp_v_o); end
      checks++; if (io_resp_o !== ex[k]) begin failures++; $display("FAIL bp_beat %0d got %h want %h", k, io_resp_o, ex[k]); end
      checks++; if (io_cmd_ready_and_o !== 1'b0) begin failures++; $display("FAIL bp_cmd_rdy got %b want 0", io_cmd_ready_and_o); end
      io_resp_ready_and_i = (c % 2 == 1);
      @(negedge clk);
      if (io_resp_ready_and_i) k++;
    end
    io_resp_ready_and_i = 1'b0;
    checks++; if (!(o1 && o2 && o3 && o4) || k != 2) begin failures++; $display("FAIL bp_done got %0d want 2", k); end
    checks++; if (io_cmd_ready_and_o !== 1'b1) begin failures++; $display("FAIL bp_turnaround got %b want 1", io_cmd_ready_and_o); end
    put_beat({32'h9, mk_hdr(4'h1, 4'h0, 40'h300, 3'd2, 7'h0)}, o5);
    checks++; if (!o5 || io_cmd_ready_and_o !== 1'b1) begin failures++; $display("FAIL bp_next_lo got %b want 1", o5); end
    put_beat({32'hA, mk_hdr(4'h1, 4'h0, 40'h304, 3'd2, 7'h0)}, o5);
    get_wide(w, o1);
    checks++; if (w[WW-1:HW] !== 64'hA_0000_0009) begin failures++; $display("FAIL bp_next_wide got %h want a00000009", w[WW-1:HW]); end
    put_resp('0, o1);
    get_narrow(ex[0], o1);
    get_narrow(ex[0], o1);
  endtask

  task automatic test_error;
    logic [WW-1:0] w, wexp;
    logic [NW-1:0] r0, r1;
    bit ok, lc, lr, ra, o1, o2, exp_e;
    exp_e = faulty(3'd2, 40'h100, 4'h1, 4'h1, 40'h10C);
    put_beat({32'h1, mk_hdr(4'h1, 4'h0, 40'h100, 3'd2, 7'h0)}, o1);
    checks++; if (error_o !== 1'b0) begin failures++; $display("FAIL err_first got %b want 0", error_o); end
    put_beat({32'h2, mk_hdr(4'h1, 4'h0, 40'h10C, 3'd2, 7'h0)}, o2);
    checks++; if (error_o !== exp_e) begin failures++; $display("FAIL err_set got %b want %b", error_o, exp_e); end
    wexp = {64'h2_0000_0001, mk_hdr(4'h1, 4'h0, 40'h100, 3'd3, 7'h0)};
    get_wide(w, ok);
    checks++; if (!(ok && o1 && o2) || w !== wexp) begin failures++; $display("FAIL err_wide got %h want %h", w, wexp); end
    put_resp('0, ok);
    get_narrow(r0, ok);
    get_narrow(r1, ok);
    do_txn({32'h0, mk_hdr(4'h0, 4'h0, 40'h500, 3'd2, 7'h0)}, {32'h0, mk_hdr(4'h0, 4'h0, 40'h504, 3'd2, 7'h0)},
           '0, w, r0, r1, ok, lc, lr, ra);
    checks++; if (error_o !== exp_e) begin failures++; $display("FAIL err_sticky got %b want %b", error_o, exp_e); end
  endtask

  task automatic test_reset_mid;
    logic [WW-1:0] w, wexp;
    logic [NW-1:0] r0, r1, e1;
    bit ok, o1, o2, lc, lr, ra;
    put_beat({32'h1, mk_hdr(4'h0, 4'h0, 40'h600, 3'd2, 7'h0)}, o1);
    put_beat({32'h2, mk_hdr(4'h0, 4'h0, 40'h604, 3'd2, 7'h0)}, o2);
    get_wide(w, ok);
    checks++; if (!(ok && o1 && o2) || io_resp_ready_and_o !== 1'b1) begin failures++; $display("FAIL mid_in_wait got %b want 1", io_resp_ready_and_o); end
    #2 reset_ni = 1'b0;
    #1;
    checks++; if ({io_cmd_v_o, io_resp_v_o, io_cmd_ready_and_o, io_resp_ready_and_o, error_o} !== 5'b0)
      begin failures++; $display("FAIL mid_rst_outputs got %b want 00000", {io_cmd_v_o, io_resp_v_o, io_cmd_ready_and_o, io_resp_ready_and_o, error_o}); end
    @(negedge clk);
    @(negedge clk);
    reset_ni = 1'b1;
    #1;
    checks++; if (io_cmd_ready_and_o !== 1'b1 || io_resp_ready_and_o !== 1'b0) begin failures++; $display("FAIL mid_release got %b want 1", io_cmd_ready_and_o); end
    wexp = {64'h4444_0000_3333_0000, mk_hdr(4'h1, 4'h7, 40'h800, 3'd3, 7'h44)};
    e1 = {32'h0BAD_0000, mk_hdr(4'h1, 4'h7, 40'h804, 3'd2, 7'h44)};
    do_txn({32'h3333_0000, mk_hdr(4'h1, 4'h7, 40'h800, 3'd2, 7'h44)},
           {32'h4444_0000, mk_hdr(4'h1, 4'h7, 40'h804, 3'd2, 7'h44)},
           {64'h0BAD_0000_0000_0001, mk_hdr(4'h1, 4'h7, 40'h0, 3'd3, 7'h44)}, w, r0, r1, ok, lc, lr, ra);
    checks++; if (!ok || w !== wexp) begin failures++; $display("FAIL mid_next_wide got %h want %h", w, wexp); end
    checks++; if (r1 !== e1) begin failures++; $display("FAIL mid_next_resp got %h want %h", r1, e1); end
  endtask

  task automatic test_random;
    logic [31:0] ra32, rb32, d1, d2, rh, rl;
    logic [PA-1:0] a1, a2, a1p4;
    logic [3:0] op, op2, sub, sub2, rop, rsub;
    logic [6:0] pl, rpl;
    logic [2:0] sz1;
    logic [WW-1:0] w, wexp;
    logic [NW-1:0] r0, r1, e0, e1;
    bit ok, lc, lr, ra;
    exp_err = 1'b0;
    for (int t = 0; t < 30; t++) begin
      ra32 = $urandom; rb32 = $urandom;
      a1 = {ra32[7:0], rb32}; a1[2:0] = 3'b000;
      if ($urandom_range(0, 5) == 0) a1 = 40'hFF_FFFF_FFF8;
      ra32 = $urandom; op = ra32[3:0]; sub = ra32[7:4]; sub2 = ra32[11:8]; pl = ra32[18:12];
      rop = ra32[22:19]; rsub = ra32[26:23];
      rb32 = $urandom; rpl = rb32[6:0];
      d1 = $urandom; d2 = $urandom; rh = $urandom; rl = $urandom;
      sz1 = 3'd2; op2 = op;
      a2 = a1 + 40'd4;
      case ($urandom_range(0, 9))
        0: sz1 = 3'd3;
        1: begin a1[2] = 1'b1; a2 = a1 + 40'd4; end
        2: op2 = op ^ 4'h8;
        3: a2 = a1 + 40'd12;
        default: ;
      endcase
      if (faulty(sz1, a1, op, op2, a2)) exp_err = 1'b1;
      a1p4 = a1 + 40'd4;
      wexp = {d2, d1, mk_hdr(op, sub, a1, 3'd3, pl)};
      e0 = {rl, mk_hdr(rop, rsub, a1, 3'd2, rpl)};
      e1 = {rh, mk_hdr(rop, rsub, a1p4, 3'd2, rpl)};
      do_txn({d1, mk_hdr(op, sub, a1, sz1, pl)}, {d2, mk_hdr(op2, sub2, a2, 3'd2, pl ^ 7'h1)},
             {rh, rl, mk_hdr(rop, rsub, {rb32, 8'h0}, 3'd3, rpl)}, w, r0, r1, ok, lc, lr, ra);
      checks++; if (!ok || w !== wexp) begin failures++; $display("FAIL rnd_wide t=%0d got %h want %h", t, w, wexp); end
      checks++; if (r0 !== e0) begin failures++; $display("FAIL rnd_resp_lo t=%0d got %h want %h", t, r0, e0); end
      checks++; if (r1 !== e1) begin failures++; $display("FAIL rnd_resp_hi t=%0d got %h want %h", t, r1, e1); end
      checks++; if (error_o !== exp_err) begin failures++; $display("FAIL rnd_err t=%0d got %b want %b", t, error_o, exp_err); end
      checks++; if (!(lc && lr && ra)) begin failures++; $display("FAIL rnd_timing t=%0d got %b%b%b want 111", t, lc, lr, ra); end
    end
  endtask

  initial begin
    test_reset();
    test_write_pair();
    test_read_pair();
    test_cmd_stall();
    test_resp_backpressure();
    test_error();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
